// File: rtl/output_delta.sv
// Output-layer error stage: delta_j = (a_j - y_j) * sigma'_j in signed Q8.24, streamed with index/last.
// Optional squared-error cost accumulator enabled by defining OUTPUT_DELTA_COST_EN.
module output_delta #(
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 24,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  label,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_activ,
  input  logic [DATA_W-1:0] in_sigma_prime,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_delta,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] cost
);

  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned EXT_W  = DATA_W + 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic signed [EXT_W-1:0]  E_MAX = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0]  E_MIN = {2'b11, {(DATA_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] P_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] P_MIN = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          in_count, out_count;
  logic [IDX_W-1:0]          label_q;
  logic                      en, in_fire, out_fire, start_acc;

  logic                      v1;
  logic signed [DATA_W-1:0]  e1, sp1;
  logic [IDX_W-1:0]          idx1;

  logic signed [EXT_W-1:0]   y_ext, diff;
  logic signed [DATA_W-1:0]  e_sat;
  logic signed [PROD_W-1:0]  ea, sb, prod, prod_sh;
  logic [DATA_W-1:0]         p_sat;

  assign en        = !out_valid || out_ready;
  assign in_ready  = (state_q == RUN) && en && (in_count < CNT_W'(N_OUT));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign start_acc = (state_q == IDLE) && start;

  // Stage-1 error: 33-bit a - y, saturated back to DATA_W
  always_comb begin
    y_ext = '0;
    if (CNT_W'(label_q) == in_count) y_ext = EXT_W'(1) << FRAC_W;
    diff = {in_activ[DATA_W-1], in_activ} - y_ext;
    if (diff > E_MAX)      e_sat = E_MAX[DATA_W-1:0];
    else if (diff < E_MIN) e_sat = E_MIN[DATA_W-1:0];
    else                   e_sat = diff[DATA_W-1:0];
  end

  // Stage-2 product: full-width signed multiply, arithmetic shift, saturate
  always_comb begin
    ea      = {{DATA_W{e1[DATA_W-1]}}, e1};
    sb      = {{DATA_W{sp1[DATA_W-1]}}, sp1};
    prod    = ea * sb;
    prod_sh = prod >>> FRAC_W;
    if (prod_sh > P_MAX)      p_sat = P_MAX[DATA_W-1:0];
    else if (prod_sh < P_MIN) p_sat = P_MIN[DATA_W-1:0];
    else                      p_sat = prod_sh[DATA_W-1:0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (in_count == CNT_W'(N_OUT)) state_d = DRAIN;
      DRAIN:   if (out_fire && out_count == CNT_W'(N_OUT - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with registered status decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN) || (state_d == DRAIN);
      done    <= (state_d == DONE);
    end
  end

  // Sample counters and latched label
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_count  <= '0;
      out_count <= '0;
      label_q   <= '0;
    end else if (start_acc) begin
      in_count  <= '0;
      out_count <= '0;
      label_q   <= label;
    end else begin
      if (in_fire)  in_count  <= in_count + CNT_W'(1);
      if (out_fire) out_count <= out_count + CNT_W'(1);
    end
  end

  // Two-stage pipeline, advanced globally by en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      e1        <= '0;
      sp1       <= '0;
      idx1      <= '0;
      out_valid <= 1'b0;
      out_delta <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      v1 <= in_fire;
      if (in_fire) begin
        e1   <= e_sat;
        sp1  <= in_sigma_prime;
        idx1 <= in_count[IDX_W-1:0];
      end
      out_valid <= v1;
      out_last  <= v1 && (idx1 == IDX_W'(N_OUT - 1));
      if (v1) begin
        out_delta <= p_sat;
        out_idx   <= idx1;
      end
    end
  end

`ifdef OUTPUT_DELTA_COST_EN
  logic signed [PROD_W-1:0] sq;
  logic [PROD_W-1:0]        sq_sh;
  logic [DATA_W-1:0]        sq_sat, cost_n;
  logic [DATA_W:0]          cost_sum;

  // Squared error term, unsigned saturating accumulate
  always_comb begin
    sq       = ea * ea;
    sq_sh    = sq >> FRAC_W;
    sq_sat   = (|sq_sh[PROD_W-1:DATA_W]) ? {DATA_W{1'b1}} : sq_sh[DATA_W-1:0];
    cost_sum = {1'b0, cost} + {1'b0, sq_sat};
    cost_n   = cost_sum[DATA_W] ? {DATA_W{1'b1}} : cost_sum[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cost <= '0;
    else if (start_acc)  cost <= '0;
    else if (en && v1)   cost <= cost_n;
  end
`else
  assign cost = '0;
`endif

endmodule

// File: tb/tb_output_delta.sv
// Scoreboard bench for output_delta: driver pushes expected deltas, a negedge monitor pops and compares.
module tb_output_delta;
  localparam int unsigned N_OUT = 10, DATA_W = 32, IDX_W = 4;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [IDX_W-1:0]  label = '0;
  logic              in_valid = 1'b0, in_ready;
  logic [DATA_W-1:0] in_activ = '0, in_sigma_prime = '0;
  logic              out_valid, out_ready = 1'b1, out_last, busy, done;
  logic [DATA_W-1:0] out_delta, cost;
  logic [IDX_W-1:0]  out_idx;

  output_delta dut (
    .clk(clk), .rst_n(rst_n), .start(start), .label(label),
    .in_valid(in_valid), .in_ready(in_ready), .in_activ(in_activ),
    .in_sigma_prime(in_sigma_prime), .out_valid(out_valid), .out_ready(out_ready),
    .out_delta(out_delta), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done), .cost(cost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } exp_t;

  exp_t        sb[$];
  int          cmp = 0, mism = 0, cyc = 0, done_cnt = 0, lat_acc = 0;
  bit          lat_arm = 1'b0;
  logic [31:0] a_v[N_OUT], sp_v[N_OUT], ex_v[N_OUT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp++;
    if (act !== req) begin
      mism++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_uniform(input logic [31:0] a, input logic [31:0] sp,
                             input logic [31:0] ex_other, input int tgt, input logic [31:0] ex_tgt);
    for (int j = 0; j < N_OUT; j++) begin
      a_v[j] = a; sp_v[j] = sp; ex_v[j] = (j == tgt) ? ex_tgt : ex_other;
    end
  endtask

  task automatic drive(input logic [IDX_W-1:0] lbl, input int n, input bit arm);
    bit   got;
    exp_t e;
    start = 1'b1; label = lbl;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1; in_activ = a_v[j]; in_sigma_prime = sp_v[j];
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        got = in_ready;
        if (got) begin
          e.d = ex_v[j]; e.idx = IDX_W'(j); e.last = (j == N_OUT - 1);
          sb.push_back(e);
          if (arm && j == 0) begin lat_acc = cyc; lat_arm = 1'b1; end
        end
        @(posedge clk); #1;
      end
      if (!got) check("accept_timeout", 32'(j), 32'hFFFF_FFFF);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    d0 = done_cnt;
    for (int t = 0; t < 300 && done_cnt == d0; t++) begin
      @(negedge clk); #1;
    end
    check({name, "_done"}, 32'(done_cnt - d0), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops expected deltas on every output handshake, checks holds under stall
  initial begin
    bit   stall_p;
    exp_t held, e;
    stall_p = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!rst_n) begin
        stall_p = 1'b0;
      end else begin
        if (stall_p) begin
          check("hold_delta", out_delta, held.d);
          check("hold_idx", 32'(out_idx), 32'(held.idx));
          check("hold_last", 32'(out_last), 32'(held.last));
        end
        if (out_valid && lat_arm) begin
          lat_arm = 1'b0;
          check("latency", 32'(cyc - lat_acc), 32'd2);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 32'(out_idx), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("delta", out_delta, e.d);
            check("idx", 32'(out_idx), 32'(e.idx));
            check("last", 32'(out_last), 32'(e.last));
          end
        end
        stall_p = out_valid && !out_ready;
        held.d = out_delta; held.idx = out_idx; held.last = out_last;
      end
    end
  end

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_delta", out_delta, 32'd0);
    check("rst_cost", cost, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // label match, non-target, positive and negative saturation, zeros
    set_uniform(32'h0, 32'h0100_0000, 32'h0, 0, 32'h0);
    a_v[0] = 32'h00C0_0000; sp_v[0] = 32'h0030_0000; ex_v[0] = 32'hFFF4_0000;
    a_v[1] = 32'h0080_0000; sp_v[1] = 32'h0040_0000; ex_v[1] = 32'h0020_0000;
    a_v[2] = 32'h7F00_0000; sp_v[2] = 32'h7F00_0000; ex_v[2] = 32'h7FFF_FFFF;
    a_v[3] = 32'h8000_0000; sp_v[3] = 32'h7F00_0000; ex_v[3] = 32'h8000_0000;
    drive(4'd0, N_OUT, 1'b1);
    wait_done("basic");

    // backpressure: out_ready low for 5 cycles mid-stream
    set_uniform(32'h0080_0000, 32'h0040_0000, 32'h0020_0000, 2, 32'hFFE0_0000);
    fork
      drive(4'd2, N_OUT, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_done("backpressure");

    // cost sample
    set_uniform(32'h0080_0000, 32'h0100_0000, 32'h0080_0000, 3, 32'hFF80_0000);
    drive(4'd3, N_OUT, 1'b0);
    wait_done("cost");
`ifdef OUTPUT_DELTA_COST_EN
    check("cost_value", cost, 32'h0280_0000);
`else
    check("cost_value", cost, 32'h0);
`endif

    // label out of range: all targets zero
    set_uniform(32'h0080_0000, 32'h0100_0000, 32'h0080_0000, 0, 32'h0080_0000);
    drive(4'd12, N_OUT, 1'b0);
    wait_done("label_oor");

    // reset after 4 accepts, then a fresh sample
    set_uniform(32'h0080_0000, 32'h0100_0000, 32'h0080_0000, 3, 32'hFF80_0000);
    drive(4'd3, 4, 1'b0);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_delta_idx", out_delta | 32'(out_idx), 32'd0);
    check("mid_rst_flags", {28'd0, out_last, busy, done, in_ready}, 32'd0);
    check("mid_rst_cost", cost, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    drive(4'd3, N_OUT, 1'b0);
    wait_done("after_rst");
`ifdef OUTPUT_DELTA_COST_EN
    check("after_rst_cost", cost, 32'h0280_0000);
`else
    check("after_rst_cost", cost, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule

// File: doc/output_delta.md
Name: output_delta

Overview:
- Output-layer error stage of the backprop datapath; sits directly downstream of the output-layer neurons.
- Consumes a stream of N_OUT (activ, sigma_prime) pairs plus a class label.
- Computes delta_j = (a_j - y_j) * sigma'_j in signed Q8.24 and streams the deltas to the weight-update stage.
- Target y_j = 1.0 (0x01000000) when j == label, else 0.

Parameters:
- N_OUT, 10, number of output neurons per sample
- DATA_W, 32, fixed-point word width
- FRAC_W, 24, fractional bits (Q8.24)
- IDX_W, 4, width of neuron index and label (ceil log2 N_OUT)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sample; honoured only in IDLE
- label  input  IDX_W  target class, sampled on accepted start
- in_valid  input  1  input pair valid
- in_ready  output  1  stage can accept a pair
- in_activ  input  DATA_W  neuron activation a_j, Q8.24 signed
- in_sigma_prime  input  DATA_W  sigma'(z_j), Q8.24 signed
- out_valid  output  1  delta valid
- out_ready  input  1  downstream accepts delta
- out_delta  output  DATA_W  delta_j, Q8.24 signed
- out_idx  output  IDX_W  neuron index j of out_delta
- out_last  output  1  high with delta of index N_OUT-1
- busy  output  1  high in RUN and DRAIN
- done  output  1  one-cycle pulse after last delta accepted
- cost  output  DATA_W  accumulated cost (see Optional Feature)

Behaviour:
- Reset, asynchronous, active-low: state=IDLE; in_ready, out_valid, out_last, busy, done = 0; out_delta, out_idx, cost = 0; counters and pipeline cleared. Reset mid-sample discards all in-flight data; no done pulse is issued.
- FSM:
  - IDLE: start=1 latches label, clears in/out counters, goes to RUN.
  - RUN: accepts pairs; after N_OUT accepts, goes to DRAIN.
  - DRAIN: waits for the last output handshake (out_idx = N_OUT-1), then goes to DONE.
  - DONE: done=1 for one cycle, then returns to IDLE.
  - start outside IDLE is ignored.
- Handshakes:
  - Input accepted on in_valid & in_ready.
  - Output transferred on out_valid & out_ready.
  - out_delta, out_idx and out_last hold stable while out_valid & !out_ready.
- Pipeline, 2 stages with global advance en = !out_valid | out_ready:
  - S1 registers e = a - y (33-bit signed, then saturated to DATA_W), sigma', and idx.
  - S2 registers the output: p = e * sigma' (64-bit signed), shifted arithmetic right by FRAC_W (truncation toward -inf), saturated to [0x80000000, 0x7FFFFFFF].
- in_ready = (state==RUN) & en & (in_count < N_OUT).
- Latency: accept -> out_valid is 2 cycles with no backpressure. Throughput is 1 pair/cycle.
- label >= N_OUT: every y_j = 0. This is not an error.
- in_count and out_count do not wrap. Inputs beyond N_OUT are refused (in_ready=0).

Optional Feature:
- Macro: OUTPUT_DELTA_COST_EN.
- Defined:
  - S2 also accumulates cost += (e*e) >> FRAC_W, unsigned, saturating at 0xFFFFFFFF.
  - cost clears on accepted start and is stable from done onward.
- Undefined:
  - cost tied to 0; no squaring multiplier is instantiated.

Test Plan:
- Label match: label=0, j=0 with a=0x00C00000, sp=0x00300000 -> out_delta=0xFFF40000, out_idx=0, out_valid 2 cycles after accept.
- Non-target: label=0, j=1 with a=0x00800000, sp=0x00400000 -> out_delta=0x00200000, out_idx=1.
- Saturation: a=0x7F000000, sp=0x7F000000, non-target -> out_delta=0x7FFFFFFF. Negative case a=0x80000000, sp=0x7F000000 -> out_delta=0x80000000.
- Backpressure: full 10-sample stream with out_ready low for 5 cycles mid-stream -> outputs held stable, in_ready drops, all 10 deltas delivered in order, out_last only at idx 9, done pulses once.
- Cost (macro on): label=3, all a=0x00800000, sp=0x01000000 -> deltas 0x00800000 except idx3=0xFF800000; cost=0x02800000 at done. Macro off -> cost=0.
- Reset mid-run: assert rst_n=0 after 4 accepts -> all outputs 0 immediately, state IDLE, no done. Next start processes a full fresh sample correctly.
